// File: rtl/pos_cell_ctrl_pkg.sv
// rtl/pos_cell_ctrl_pkg.sv - shared types and constants for the cell position access controller
// Contents: controller state enum, count-word field position and width,
//           default position word width, and the output FIFO entry layout.
package pos_cell_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT,
        ST_CNT_WAIT,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    // Particle count lives in the low bits of RAM word 0
    localparam int CNT_LSB   = 0;
    localparam int CNT_WIDTH = 8;
    localparam int POS_WIDTH = 96;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] addr;
        logic                 last;
        logic [POS_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pos_cell_out_fifo.sv
// rtl/pos_cell_out_fifo.sv - small synchronous valid/ready FIFO holding streamed particle words
// Ports: clk, rst_n (async active-low), push/push_data (write side, caller guarantees space),
//        out_valid/out_ready/out_data (read side), occupancy (entries currently held).
module pos_cell_out_fifo #(
    parameter int WIDTH = 105,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;

    assign out_valid = (occupancy != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (PW+1)'(1);
                2'b01:   occupancy <= occupancy - (PW+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/pos_cell_access_ctrl.sv
// rtl/pos_cell_access_ctrl.sv - arbitration and read sequencing in front of a single-port cell position RAM
// Ports: rd_start/rd_busy/rd_done/cnt_err (cell read job control), out_* (streamed particles,
//        valid/ready), wr_* (single-word write-backs), ram_* (registered RAM interface, 2-cycle ram_q).
module pos_cell_access_ctrl
    import pos_cell_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = POS_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = CNT_WIDTH,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  cnt_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    localparam int ENTRY_W = ADDR_WIDTH + 1 + DATA_WIDTH;
    localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W   = OCC_W + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  tag_s1, tag_s2;
    logic [ADDR_WIDTH-1:0] addr_s1, addr_s2;
    logic [ENTRY_W-1:0]    fifo_in, fifo_out;
    logic [OCC_W-1:0]      occupancy;
    logic                  fifo_push, fifo_pop;
    logic [ADDR_WIDTH-1:0] cnt_field, cnt_clamped;
    logic [CRD_W-1:0]      credit_used;
    logic                  issue_ok;

    assign fifo_push = ((state == ST_STREAM) || (state == ST_DRAIN)) && tag_s2;
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_in   = {addr_s2, (addr_s2 == count), ram_q};

    // Credits: FIFO entries left after this cycle's pop, plus every read issued but not yet
    // pushed (on ram_rden now, in tag stage 1, or being pushed from tag stage 2).
    assign credit_used = CRD_W'(occupancy) - CRD_W'(fifo_pop)
                       + CRD_W'(ram_rden) + CRD_W'(tag_s1) + CRD_W'(tag_s2);
    assign issue_ok    = credit_used < CRD_W'(FIFO_DEPTH);

    assign cnt_field   = ram_q[CNT_LSB +: ADDR_WIDTH];
    assign cnt_clamped = (cnt_field > MAX_ADDR) ? MAX_ADDR : cnt_field;

    // rd_busy stays high for the closing cycle, so IDLE only serves requests once it drops
    assign wr_ready = (state == ST_IDLE) && !rd_busy && !rd_start;

    pos_cell_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out),
        .occupancy (occupancy)
    );

    assign out_addr = fifo_out[ENTRY_W-1 -: ADDR_WIDTH];
    assign out_last = fifo_out[DATA_WIDTH];
    assign out_data = fifo_out[DATA_WIDTH-1:0];

    // Read tag pipeline: ram_rden is stage 0, ram_q lines up with tag_s2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_s1  <= 1'b0;
            tag_s2  <= 1'b0;
            addr_s1 <= '0;
            addr_s2 <= '0;
        end else begin
            tag_s1  <= ram_rden;
            tag_s2  <= tag_s1;
            addr_s1 <= ram_address;
            addr_s2 <= addr_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rd_busy     <= 1'b0;
            rd_done     <= 1'b0;
            cnt_err     <= 1'b0;
            wr_err      <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_rden    <= 1'b0;
            ram_wren    <= 1'b0;
            count       <= '0;
            next_addr   <= '0;
        end else begin
            ram_rden <= 1'b0;
            ram_wren <= 1'b0;
            rd_done  <= 1'b0;
            wr_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_busy) begin
                        rd_busy <= 1'b0;
                    end else if (rd_start) begin
                        state       <= ST_CNT;
                        rd_busy     <= 1'b1;
                        cnt_err     <= 1'b0;
                        ram_address <= '0;
                        ram_rden    <= 1'b1;
                    end else if (wr_valid && wr_ready) begin
                        if (wr_addr > MAX_ADDR) begin
                            wr_err <= 1'b1;
                        end else begin
                            ram_wren    <= 1'b1;
                            ram_address <= wr_addr;
                            ram_data    <= wr_data;
                        end
                    end
                end
                ST_CNT: state <= ST_CNT_WAIT;
                ST_CNT_WAIT: begin
                    if (tag_s2) begin
                        count <= cnt_clamped;
                        if (cnt_field > MAX_ADDR) cnt_err <= 1'b1;
                        if (cnt_clamped == '0) begin
                            rd_done <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            // Count arrives straight from ram_q, so address 1 is issued immediately
                            ram_address <= ADDR_WIDTH'(1);
                            ram_rden    <= 1'b1;
                            next_addr   <= ADDR_WIDTH'(2);
                            state       <= (cnt_clamped == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (issue_ok) begin
                        ram_address <= next_addr;
                        ram_rden    <= 1'b1;
                        next_addr   <= next_addr + ADDR_WIDTH'(1);
                        if (next_addr == count) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Zero credits means nothing in flight and the FIFO empties this cycle
                    if (credit_used == '0) begin
                        rd_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// tb/tb_pos_cell_access_ctrl.sv - randomized scoreboard bench for pos_cell_access_ctrl
module tb_pos_cell_access_ctrl;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int FD = 4;

    typedef struct packed { logic [AW-1:0] addr; logic last; logic [DW-1:0] data; } exp_t;
    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rd_start = 1'b0;
    logic out_ready = 1'b0;
    logic wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic rd_busy, rd_done, cnt_err, out_valid, out_last, wr_ready, wr_err, ram_rden, ram_wren;
    logic [DW-1:0] out_data, ram_data, ram_q;
    logic [AW-1:0] out_addr, ram_address;

    always #5 clk = ~clk;

    pos_cell_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_busy(rd_busy), .rd_done(rd_done),
        .cnt_err(cnt_err), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err), .ram_address(ram_address),
        .ram_data(ram_data), .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // RAM with 2-cycle read latency; ram_q holds when not read
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] q_s1 = '0, q_s2 = '0;
    assign ram_q = q_s2;
    initial forever begin
        @(posedge clk);
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        if (ram_rden) q_s1 <= ram_mem[ram_address];
        q_s2 <= q_s1;
    end

    int cyc = 0;
    initial forever begin @(posedge clk); cyc <= cyc + 1; end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model and scoreboard state
    logic [DW-1:0] ref_mem [256];
    exp_t  exp_rd_q [$];
    wexp_t exp_wr_q [$];
    int exp_wr_err = 0, wr_err_seen = 0;
    logic exp_cerr = 1'b0;
    int job_start = 0, first_valid = -1, done_rel = -1, done_cnt = 0, busy_first = -1, busy_last = -1;
    int ready_mode = 0;
    logic prev_stall = 1'b0;
    logic [AW+DW:0] prev_out = '0;

    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: samples on the falling edge, pops expectations when the DUT presents data
    initial forever begin
        exp_t e;
        wexp_t w;
        @(negedge clk);
        if (prev_stall) chk("stall_hold", {out_valid, out_addr, out_last, out_data}, {1'b1, prev_out});
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_addr, out_last, out_data};
        if (out_valid && out_ready) begin
            if (exp_rd_q.size() == 0) chk("out_unexpected", 1, 0);
            else begin
                e = exp_rd_q.pop_front();
                chk("out_addr", out_addr, e.addr);
                chk("out_data", out_data, e.data);
                chk("out_last", out_last, e.last);
            end
        end
        if (out_valid && first_valid < 0) first_valid = cyc - job_start;
        if (rd_done) begin done_cnt++; done_rel = cyc - job_start; end
        if (rd_busy) begin
            if (busy_first < 0) busy_first = cyc - job_start;
            busy_last = cyc - job_start;
        end
        if (ram_rden && ram_wren) chk("rden_wren_both", 1, 0);
        if (ram_wren && rd_busy) chk("write_while_busy", 1, 0);
        if (dut.u_fifo.occupancy > FD) chk("fifo_overflow", dut.u_fifo.occupancy, FD);
        if (ram_wren) begin
            if (exp_wr_q.size() == 0) chk("wren_unexpected", ram_address, 0);
            else begin
                w = exp_wr_q.pop_front();
                chk("wr_addr", ram_address, w.addr);
                chk("wr_data", ram_data, w.data);
            end
        end
        if (wr_err) wr_err_seen++;
    end

    function automatic logic [DW-1:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Starts and ends at posedge+1
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, output int acc_cyc);
        int t = 0;
        logic acc = 1'b0;
        wr_valid = 1'b1; wr_addr = addr; wr_data = data;
        acc_cyc = -1;
        while (!acc && t < 3000) begin
            @(negedge clk);
            acc = wr_ready;
            t++;
            if (!acc) begin @(posedge clk); #1; end
        end
        if (acc) begin
            acc_cyc = cyc;
            if (int'(addr) < PN) begin
                ref_mem[addr] = data;
                exp_wr_q.push_back({addr, data});
            end else exp_wr_err++;
        end else chk("wr_timeout", 1, 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic start_job(output logic wr_ready_c0, output logic cnt_err_c1);
        int n;
        exp_t e;
        n = int'(ref_mem[0][AW-1:0]);
        exp_cerr = (n > PN - 1);
        if (n > PN - 1) n = PN - 1;
        for (int a = 1; a <= n; a++) begin
            e.addr = AW'(a); e.last = (a == n); e.data = ref_mem[a];
            exp_rd_q.push_back(e);
        end
        job_start = cyc; first_valid = -1; done_rel = -1; done_cnt = 0; busy_first = -1; busy_last = -1;
        rd_start = 1'b1;
        @(negedge clk); wr_ready_c0 = wr_ready;
        @(posedge clk); #1; rd_start = 1'b0;
        @(negedge clk); cnt_err_c1 = cnt_err;
        @(posedge clk); #1;
    endtask

    task automatic finish_job();
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin @(posedge clk); #1; t++; end
        chk("job_timeout", done_cnt == 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("no_loss", exp_rd_q.size(), 0);
        chk("cnt_err", cnt_err, exp_cerr);
        chk("busy_first", busy_first, 1);
        chk("busy_last", busy_last, done_rel);
        exp_rd_q.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic c0, c1;
        int acc;
        logic [DW-1:0] w;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram", {ram_address, ram_data, ram_rden, ram_wren}, '0);
        chk("rst_out", {out_valid, out_addr, out_last, out_data, rd_busy, rd_done, cnt_err, wr_err}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int a = 1; a < PN; a++) do_write(AW'(a), rnd96(), acc);

        // Count 3, free-flowing output: exact latency
        w = rnd96(); w[7:0] = 8'd3; do_write(0, w, acc);
        ready_mode = 0;
        start_job(c0, c1); finish_job();
        chk("first_valid_cnt3", first_valid, 7);
        chk("done_cnt3", done_rel, 10);

        // Empty cell
        w = rnd96(); w[7:0] = 8'd0; do_write(0, w, acc);
        start_job(c0, c1); finish_job();
        chk("no_out_cnt0", first_valid < 0, 1);
        chk("done_cnt0", done_rel, 4);

        // Full cell with output toggling
        w = rnd96(); w[7:0] = 8'd219; do_write(0, w, acc);
        ready_mode = 1;
        start_job(c0, c1); finish_job();

        // Oversized count clamps and flags, flag clears on next start
        w = rnd96(); w[7:0] = 8'd250; do_write(0, w, acc);
        ready_mode = 2;
        start_job(c0, c1); finish_job();
        w = rnd96(); w[7:0] = 8'd2; do_write(0, w, acc);
        chk("cnt_err_sticky", cnt_err, 1);
        ready_mode = 0;

        // rd_start beats a same-cycle write, write lands right after rd_done
        wr_valid = 1'b1; wr_addr = 8'd10; wr_data = rnd96();
        start_job(c0, c1);
        chk("wr_blocked_by_start", c0, 0);
        chk("cnt_err_cleared", c1, 0);
        do_write(8'd10, rnd96(), acc);
        chk("wr_after_done", acc - job_start, done_rel + 1);
        finish_job();

        // Back-to-back legal and illegal writes
        do_write(8'd5, rnd96(), acc);
        do_write(8'd230, rnd96(), acc);
        repeat (3) @(posedge clk);
        #1;
        chk("wr_err_count", wr_err_seen, exp_wr_err);
        chk("wr_queue_empty", exp_wr_q.size(), 0);

        for (int k = 0; k < 6; k++) begin
            repeat (3) do_write(AW'($urandom_range(1, 255)), rnd96(), acc);
            w = rnd96(); w[7:0] = AW'($urandom_range(0, 255)); do_write(0, w, acc);
            ready_mode = k % 3;
            start_job(c0, c1); finish_job();
        end

        // Reset in the middle of a stream
        w = rnd96(); w[7:0] = 8'd219; do_write(0, w, acc);
        ready_mode = 0;
        start_job(c0, c1);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ram", {ram_address, ram_data, ram_rden, ram_wren}, '0);
        chk("midrst_out", {out_valid, out_addr, out_last, out_data, rd_busy, rd_done, cnt_err, wr_err}, '0);
        exp_rd_q.delete();
        prev_stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        w = rnd96(); w[7:0] = 8'd3; do_write(0, w, acc);
        start_job(c0, c1); finish_job();
        chk("first_valid_after_rst", first_valid, 7);
        chk("done_after_rst", done_rel, 10);
        chk("wr_err_final", wr_err_seen, exp_wr_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pos_cell_access_ctrl.md
Name: pos_cell_access_ctrl

Overview:
Sequencing and arbitration controller in front of one single-port cell position RAM (2-cycle read latency, word 0 = particle count, words 1..N = {posz,posy,posx}).
- Serves two requesters: a force-evaluation read job that streams a whole cell, and motion-update single-word write-backs.
- A read job owns the RAM from start to done; writes are accepted only between jobs.
- Read data goes through a small credit-protected output FIFO, so downstream backpressure never loses RAM data.

Parameters:
- DATA_WIDTH, 96, width of one RAM word ({posz,posy,posx}, 32b each).
- PARTICLE_NUM, 220, RAM depth; legal particle addresses are 1..PARTICLE_NUM-1.
- ADDR_WIDTH, 8, RAM address width.
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ 3 (power of two).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_start  in  1  one-cycle request to stream the cell; ignored unless idle.
- rd_busy  out  1  read job in progress.
- rd_done  out  1  one-cycle pulse at job end.
- cnt_err  out  1  stored count exceeded PARTICLE_NUM-1; sticky until next accepted rd_start.
- out_valid  out  1  particle word available.
- out_ready  in  1  consumer accepts the particle word.
- out_data  out  DATA_WIDTH  particle position.
- out_addr  out  ADDR_WIDTH  RAM address of the particle (1-based).
- out_last  out  1  marks the final particle of the job.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle.
- wr_addr  in  ADDR_WIDTH  write address (0 = count word).
- wr_data  in  DATA_WIDTH  write data.
- wr_err  out  1  one-cycle pulse: accepted write had address ≥ PARTICLE_NUM and was dropped.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_rden  out  1  to RAM rden.
- ram_wren  out  1  to RAM wren.
- ram_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after address/rden.

Behaviour:
- **Reset (async, rst_n=0):** state=IDLE; FIFO emptied; in-flight tracker cleared. All outputs 0 (ram_*, out_*, rd_*, cnt_err, wr_err); internal count register 0. A reset mid-job abandons the job with no rd_done.
- **Registered RAM interface:** all RAM outputs are registered. A decision made at cycle c appears on ram_* at c+1; the corresponding ram_q is valid at c+3.
- **States:**
  - IDLE: wr_ready = !rd_start. rd_start has priority over a same-cycle wr_valid. rd_start → CNT, and clears cnt_err.
  - CNT: drive ram_address=0, ram_rden=1 for one cycle → CNT_WAIT.
  - CNT_WAIT: wait for the count word on ram_q. Capture count = ram_q[ADDR_WIDTH-1:0]. If count > PARTICLE_NUM-1, clamp it and set cnt_err. If count==0, pulse rd_done next cycle → IDLE. Otherwise → STREAM with next_addr=1.
  - STREAM: issue ram_rden at next_addr only when fifo_occupancy + inflight < FIFO_DEPTH; increment next_addr on each issue. After issuing addr==count → DRAIN.
  - DRAIN: wait until inflight==0 and the FIFO is empty. rd_done pulses the cycle after the last out handshake → IDLE.
- **Read capture:** a 2-stage valid shift register tags issued reads. A tagged ram_q is written into the FIFO together with its address and last flag (addr==count).
- **Read latency:** rd_start at cycle 0 → count read cycle 1 → count captured cycle 3 → first particle read cycle 4 → first out_valid cycle 7.
- **Throughput:** sustained 1 particle/cycle while out_ready=1.
- **Output FIFO:** standard valid/ready. out_* is stable while out_valid && !out_ready. Simultaneous push/pop at full or empty is legal. Overflow is impossible by credit; a bench assertion checks it.
- **Writes:** handshake wr_valid && wr_ready. Accepted writes produce ram_wren=1 with registered address/data next cycle.
  - An address ≥ PARTICLE_NUM is dropped (no ram_wren) and wr_err pulses.
  - Writes never occur while rd_busy.
- **rd_busy:** high from the cycle after rd_start through the cycle rd_done pulses.
- **ram_rden / ram_wren** are never both high.

Decomposition:
- Package pos_cell_ctrl_pkg holds:
  - the state enum;
  - the count field LSB and width constants;
  - the FIFO entry struct {addr, last, data}.
- Sub-module pos_cell_out_fifo: parameterised synchronous FIFO with registered outputs, occupancy output, valid/ready.

Test Plan:
- Count word=3, out_ready=1, rd_start at cycle 0 → out_valid at cycles 7,8,9 with out_addr 1,2,3; out_last on addr 3; rd_done at cycle 10.
- Count=0 → no out_valid; rd_done at cycle 4; rd_busy high cycles 1-4.
- Count=219, out_ready toggling 1/0 per cycle → all 219 words in order, no loss or duplication; FIFO occupancy never exceeds 4.
- Count word=250 → cnt_err=1; exactly 219 particles streamed; cnt_err cleared on the next rd_start.
- Same cycle rd_start=1 and wr_valid=1 in IDLE → wr_ready=0; the write is accepted the cycle after rd_done.
- Back-to-back writes to addr 5 and addr 230 → ram_wren at addr 5 only; wr_err pulses for 230.
- rst_n low mid-STREAM → all outputs 0 immediately; next rd_start behaves as a fresh job.
